// File: rtl/sha256_message_schedule_if.sv
// Handshake bundle between the padding stage, the schedule expander and the
// compression rounds: one block-load channel and one word-stream channel.
// Vectors use ascending ranges so that bit 0 is the MSB of each big-endian word.
interface sha256_message_schedule_if;
   logic          block_valid;
   logic          block_ready;
   logic [0:511]  block_in;
   logic          w_valid;
   logic          w_ready;
   logic [0:31]   w_out;
   logic [0:5]    w_index;
   logic          w_last;

   // Producer/consumer side (padding stage and compression rounds)
   modport master (
      output block_valid, block_in, w_ready,
      input  block_ready, w_valid, w_out, w_index, w_last
   );

   // Schedule expander side
   modport slave (
      input  block_valid, block_in, w_ready,
      output block_ready, w_valid, w_out, w_index, w_last
   );
endinterface

// File: rtl/sha256_message_schedule.sv
// SHA-256 message-schedule expander. Loads one padded 512-bit block, then
// streams W[0]..W[NUM_ROUNDS-1] one word per handshake. Only a 16-word
// circular buffer is kept: W[t] for t >= 16 overwrites W[t-16] once consumed.
module sha256_message_schedule #(
   parameter int NUM_ROUNDS = 64
) (
   input logic                      clk,
   input logic                      reset,
   sha256_message_schedule_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

   state_t      state_r;
   state_t      state_next_s;
   logic [31:0] buf_r [16];
   logic [5:0]  t_r;
   logic [31:0] w_sel_s;
   logic [3:0]  slot_s;

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
   endfunction

   assign slot_s = t_r[3:0];

   // Next-state and handshake outputs of the load/emit sequencer
   always_comb begin
      state_next_s    = state_r;
      bus.block_ready = 1'b0;
      bus.w_valid     = 1'b0;
      case (state_r)
         IDLE: begin
            bus.block_ready = 1'b1;
            if (bus.block_valid) begin
               state_next_s = EMIT;
            end else begin
               state_next_s = IDLE;
            end
         end
         EMIT: begin
            bus.w_valid = 1'b1;
            if (bus.w_ready && (t_r == LAST_T)) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = EMIT;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Current schedule word: a stored word for t < 16, otherwise the recurrence
   // over the circular buffer (slot t&15 still holds W[t-16] here)
   always_comb begin
      w_sel_s = buf_r[slot_s];
      if (t_r >= 6'd16) begin
         w_sel_s = small_sigma1(buf_r[slot_s - 4'd2]) + buf_r[slot_s - 4'd7]
                 + small_sigma0(buf_r[slot_s - 4'd15]) + buf_r[slot_s];
      end else begin
         w_sel_s = buf_r[slot_s];
      end
   end

   assign bus.w_out   = w_sel_s;
   assign bus.w_index = t_r;
   assign bus.w_last  = (state_r == EMIT) && (t_r == LAST_T);

   // Sequencer state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Word buffer and round index: load on block accept, advance on word handshake
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         t_r <= 6'd0;
         for (int k = 0; k < 16; k++) begin
            buf_r[k] <= 32'd0;
         end
      end else if ((state_r == IDLE) && bus.block_valid) begin
         t_r <= 6'd0;
         for (int k = 0; k < 16; k++) begin
            buf_r[k] <= bus.block_in[32*k +: 32];
         end
      end else if ((state_r == EMIT) && bus.w_ready) begin
         if (t_r >= 6'd16) begin
            buf_r[slot_s] <= w_sel_s;
         end
         if (t_r == LAST_T) begin
            t_r <= 6'd0;
         end else begin
            t_r <= t_r + 6'd1;
         end
      end
   end

endmodule

// File: doc/sha256_message_schedule.md
# sha256_message_schedule

Message-schedule expander for the SHA-256 datapath. It sits directly downstream of the padding stage and upstream of the compression rounds. It accepts one padded 512-bit block over a valid/ready handshake, then streams the schedule words W[0]..W[NUM_ROUNDS-1] one word per cycle over a second valid/ready handshake. Expansion uses a 16-word circular buffer, not a 64-word array.

## Interface

Parameters:
- NUM_ROUNDS, default 64: number of W words emitted per block. Legal range 16..64; full SHA-256 requires 64.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- block_valid  in  1  padded block available on block_in.
- block_ready  out  1  block accepted on a cycle where block_valid && block_ready.
- block_in  in  [0:511]  padded block; big-endian, bit 0 = MSB; word k = block_in[32k +: 32].
- w_valid  out  1  w_out holds a valid schedule word.
- w_ready  in  1  consumer takes the word on a cycle where w_valid && w_ready.
- w_out  out  [0:31]  schedule word W[t]; bit 0 = MSB.
- w_index  out  [0:5]  t, the index of the word on w_out.
- w_last  out  1  high with w_valid when t == NUM_ROUNDS-1.

## Operation

- State machine with two states: IDLE and EMIT.
- IDLE:
  - block_ready=1, w_valid=0.
  - On block accept: load buf[k] <= word k for k=0..15, set t <= 0, go to EMIT.
- EMIT:
  - block_ready=0, w_valid=1. block_valid and block_in are ignored.
- Word selection:
  - t < 16: w_out = buf[t].
  - t >= 16: w_out = σ1(buf[(t-2)&15]) + buf[(t-7)&15] + σ0(buf[(t-15)&15]) + buf[t&15], with all additions mod 2^32.
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- On a W handshake:
  - If t >= 16: buf[t&15] <= w_out. This overwrites W[t-16], which is no longer needed.
  - If t < NUM_ROUNDS-1: t <= t+1.
  - Otherwise: go to IDLE; t <= 0.
- Without a W handshake (w_ready=0): t, buf and state hold. w_out, w_index and w_last stay stable.
- w_out is a combinational function of registered buf and t only. There is no combinational path from w_ready or block_* to w_out.
- w_index is 6 bits; t never exceeds 63.

## Timing

- Reset (reset=0, asynchronous) forces:
  - state=IDLE, t=0, all buf words = 0.
  - Outputs: block_ready=1, w_valid=0, w_out=0x00000000, w_index=0, w_last=0.
- Reset deasserts synchronously to clk at the system level. The first block can be accepted on the first clock edge after deassertion.
- Latency:
  - Block accepted at edge N → w_valid=1 with W[0] in the cycle after edge N.
  - With w_ready held at 1, W[t] is presented in the cycle after edge N+t.
  - The final handshake occurs at edge N+NUM_ROUNDS.
- block_ready returns to 1 in the cycle after the last W handshake.
- Peak throughput: one block per NUM_ROUNDS+1 cycles. There is no overlap of load and emit.
- A reset assertion in mid-block drops w_valid immediately (asynchronous) and discards the block. No partial state survives.
- block_valid may stay high across blocks. The next block is taken only in IDLE.

## Test plan

- "abc" padded block (word0=0x61626380, words1..14=0, word15=0x00000018), w_ready=1:
  - W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000, W[18]=0x7DA86405, W[19]=0x600003C6, W[63]=0x12B1EDEB.
  - w_last=1 only at w_index=63; block_ready=0 from acceptance until after W[63].
- All-zero block: all 64 words are 0x00000000. Accept at edge N gives the last handshake at edge N+64, and block_ready=1 in the following cycle.
- Backpressure:
  - Stimulus: "abc" block; w_ready=0 for 5 cycles while w_index=20, plus random w_ready toggling elsewhere.
  - Required response: w_out and w_index are stable during every stall; the full sequence matches the reference model word-for-word.
- Input isolation during EMIT: toggle block_valid and randomise block_in while in EMIT. There are no extra accepts, and the emitted W sequence is unchanged.
- Reset mid-block:
  - Stimulus: assert reset at w_index=30 for 2 cycles, release, then send the "abc" block.
  - Required response: w_valid=0 and block_ready=1 during reset; the new stream starts at W[0]=0x61626380 with w_index=0.
- Back-to-back blocks: block_valid held high with two different random blocks. Each emits 64 correct words, with exactly one IDLE cycle between them. Also run NUM_ROUNDS=16: 16 words, w_last at index 15.
